// File: rtl/mc_control_pkg.sv
// Shared multicycle CPU control definitions:
// opcodes, FSM states, ALU/mux select codes.
package mc_control_pkg;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_ADDI = 6'h08;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_4     = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCS_ALU = 2'b00;
  localparam logic [1:0] PCS_OUT = 2'b01;
  localparam logic [1:0] PCS_JMP = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;
  } ctrl_t;

endpackage

// File: rtl/mc_control_outdec.sv
// State-to-control-word decoder (combinational).
// Ports: state, mem_ready in; ctrl word out.
module mc_control_outdec
  import mc_control_pkg::*;
(
  input  state_t state,
  input  logic   mem_ready,
  output ctrl_t  ctrl
);

  always_comb begin
    ctrl = '0;
    unique case (state)
      S_FETCH: begin
        ctrl.mem_read  = 1'b1;
        ctrl.alu_src_b = SRCB_4;
        ctrl.alu_op    = ALU_ADD;
        ctrl.pc_source = PCS_ALU;
        ctrl.ir_write  = mem_ready;
        ctrl.pc_write  = mem_ready;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH;
        ctrl.alu_op    = ALU_ADD;
      end
      S_MEMADR: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_MEMRD: begin
        ctrl.mem_read = 1'b1;
        ctrl.iord     = 1'b1;
      end
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.mem_write = 1'b1;
        ctrl.iord      = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.alu_op    = ALU_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a     = 1'b1;
        ctrl.alu_op        = ALU_SUB;
        ctrl.pc_write_cond = 1'b1;
        ctrl.pc_source     = PCS_OUT;
      end
      S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
      end
      S_ADDIWB: begin
        ctrl.reg_write = 1'b1;
      end
      S_JUMP: begin
        ctrl.pc_write  = 1'b1;
        ctrl.pc_source = PCS_JMP;
      end
      default: ctrl.illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/mc_control.sv
// Multicycle CPU main control FSM.
// Ports: Clk, Reset, Op, MemReady in; datapath controls, State, Illegal out.
module mc_control
  import mc_control_pkg::*;
#(
  parameter int OPW = 6,
  parameter int STW = 4
) (
  input  logic           Clk,
  input  logic           Reset,
  input  logic [OPW-1:0] Op,
  input  logic           MemReady,
  output logic           PCWrite,
  output logic           PCWriteCond,
  output logic           IorD,
  output logic           MemRead,
  output logic           MemWrite,
  output logic           IRWrite,
  output logic           MemtoReg,
  output logic           RegDst,
  output logic           RegWrite,
  output logic           ALUSrcA,
  output logic [1:0]     ALUSrcB,
  output logic [1:0]     ALUOp,
  output logic [1:0]     PCSource,
  output logic [STW-1:0] State,
  output logic           Illegal
);

  state_t     state, state_n;
  ctrl_t      ctrl;
  logic [5:0] op6;
  logic       bad_op;

  assign op6 = 6'(Op);

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_FETCH;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    bad_op  = 1'b0;
    unique case (state)
      S_FETCH:  if (MemReady) state_n = S_DECODE;
      S_DECODE: begin
        unique case (op6)
          OP_LW,
          OP_SW:   state_n = S_MEMADR;
          OP_R:    state_n = S_EXEC;
          OP_BEQ:  state_n = S_BRANCH;
          OP_ADDI: state_n = S_ADDIEX;
          OP_J:    state_n = S_JUMP;
          default: begin
            state_n = S_FETCH;
            bad_op  = 1'b1;
          end
        endcase
      end
      S_MEMADR: state_n = (op6 == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:  if (MemReady) state_n = S_MEMWB;
      S_MEMWR:  if (MemReady) state_n = S_FETCH;
      S_EXEC:   state_n = S_ALUWB;
      S_ADDIEX: state_n = S_ADDIWB;
      default:  state_n = S_FETCH;
    endcase
  end

  mc_control_outdec u_outdec (
    .state     (state),
    .mem_ready (MemReady),
    .ctrl      (ctrl)
  );

  // Reset forces FETCH, but its strobes must stay quiet until release.
  assign PCWrite     = ctrl.pc_write & ~Reset;
  assign PCWriteCond = ctrl.pc_write_cond & ~Reset;
  assign MemRead     = ctrl.mem_read & ~Reset;
  assign MemWrite    = ctrl.mem_write & ~Reset;
  assign IRWrite     = ctrl.ir_write & ~Reset;
  assign RegWrite    = ctrl.reg_write & ~Reset;
  assign Illegal     = (ctrl.illegal | bad_op) & ~Reset;

  assign IorD     = ctrl.iord;
  assign MemtoReg = ctrl.mem_to_reg;
  assign RegDst   = ctrl.reg_dst;
  assign ALUSrcA  = ctrl.alu_src_a;
  assign ALUSrcB  = ctrl.alu_src_b;
  assign ALUOp    = ctrl.alu_op;
  assign PCSource = ctrl.pc_source;
  assign State    = STW'(state);

endmodule

// File: tb/tb_mc_control.sv
// Scoreboard bench for mc_control.
// Per-cycle expectations queued at drive, checked at negedge.
module tb_mc_control;

  logic       Clk = 1'b0;
  logic       Reset;
  logic [5:0] Op;
  logic       MemReady;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite;
  logic       IRWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSource;
  logic [3:0] State;
  logic       Illegal;

  mc_control #(.OPW(6), .STW(4)) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .Op          (Op),
    .MemReady    (MemReady),
    .PCWrite     (PCWrite),
    .PCWriteCond (PCWriteCond),
    .IorD        (IorD),
    .MemRead     (MemRead),
    .MemWrite    (MemWrite),
    .IRWrite     (IRWrite),
    .MemtoReg    (MemtoReg),
    .RegDst      (RegDst),
    .RegWrite    (RegWrite),
    .ALUSrcA     (ALUSrcA),
    .ALUSrcB     (ALUSrcB),
    .ALUOp       (ALUOp),
    .PCSource    (PCSource),
    .State       (State),
    .Illegal     (Illegal)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [3:0]  st;
    logic [16:0] v;
  } exp_t;

  exp_t q[$];
  int   n_chk = 0;
  int   n_err = 0;

  logic [16:0] vec;
  assign vec = {PCWrite, PCWriteCond, IorD, MemRead,
                MemWrite, IRWrite, MemtoReg, RegDst,
                RegWrite, ALUSrcA, ALUSrcB, ALUOp,
                PCSource, Illegal};

  task automatic chk(string tag, logic [31:0] got,
                     logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t",
               tag, got, exp, $time);
    end
  endtask

  function automatic logic [16:0] exp_vec(int st,
                                          bit mr,
                                          bit ill);
    logic pcw, pcc, iod, mrd, mwr, irw, m2r, rd, rw, sa;
    logic [1:0] sb, aop, pcs;
    {pcw, pcc, iod, mrd, mwr, irw, m2r, rd, rw, sa} = '0;
    sb = 2'b00; aop = 2'b00; pcs = 2'b00;
    case (st)
      0:  begin mrd = 1; sb = 2'b01; irw = mr; pcw = mr; end
      1:  sb = 2'b11;
      2:  begin sa = 1; sb = 2'b10; end
      3:  begin mrd = 1; iod = 1; end
      4:  begin rw = 1; m2r = 1; end
      5:  begin mwr = 1; iod = 1; end
      6:  begin sa = 1; aop = 2'b10; end
      7:  begin rw = 1; rd = 1; end
      8:  begin sa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
      9:  begin sa = 1; sb = 2'b10; end
      10: rw = 1;
      11: begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcc, iod, mrd, mwr, irw, m2r, rd,
            rw, sa, sb, aop, pcs, ill};
  endfunction

  // FETCH selects with every strobe held low.
  localparam logic [16:0] RST_VEC = 17'b0000_0000_0001_0000_0;

  task automatic cyc(logic [5:0] op, bit mr,
                     int st, bit ill = 0);
    exp_t e;
    Op = op;
    MemReady = mr;
    e.st = 4'(st);
    e.v  = exp_vec(st, mr, ill);
    q.push_back(e);
    @(posedge Clk); #1;
  endtask

  always @(negedge Clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("state", 32'(State), 32'(e.st));
      chk("ctrl", 32'(vec), 32'(e.v));
    end
  end

  initial begin
    Reset = 1'b1;
    Op = 6'h00;
    MemReady = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    chk("rst_state", 32'(State), 0);
    chk("rst_ctrl", 32'(vec), 32'(RST_VEC));
    Reset = 1'b0;

    // FETCH wait, then lw
    cyc(6'h23, 0, 0);
    cyc(6'h23, 1, 0);
    cyc(6'h23, 1, 1);
    cyc(6'h23, 1, 2);
    cyc(6'h23, 1, 3);
    cyc(6'h23, 1, 4);
    // sw with 3 wait cycles in MEMWR
    cyc(6'h2B, 1, 0);
    cyc(6'h2B, 1, 1);
    cyc(6'h2B, 1, 2);
    cyc(6'h2B, 0, 5);
    cyc(6'h2B, 0, 5);
    cyc(6'h2B, 0, 5);
    cyc(6'h2B, 1, 5);
    // R-type
    cyc(6'h00, 1, 0);
    cyc(6'h00, 1, 1);
    cyc(6'h00, 1, 6);
    cyc(6'h00, 1, 7);
    // beq then j
    cyc(6'h04, 1, 0);
    cyc(6'h04, 1, 1);
    cyc(6'h04, 1, 8);
    cyc(6'h02, 1, 0);
    cyc(6'h02, 1, 1);
    cyc(6'h02, 1, 11);
    // addi
    cyc(6'h08, 1, 0);
    cyc(6'h08, 1, 1);
    cyc(6'h08, 1, 9);
    cyc(6'h08, 1, 10);
    // illegal opcode
    cyc(6'h3F, 1, 0);
    cyc(6'h3F, 1, 1, 1);
    // lw with MEMRD wait, then async reset
    cyc(6'h23, 1, 0);
    cyc(6'h23, 1, 1);
    cyc(6'h23, 1, 2);
    cyc(6'h23, 0, 3);
    MemReady = 1'b0;
    #1;
    chk("pre_rst_state", 32'(State), 3);
    Reset = 1'b1;
    #1;
    chk("async_state", 32'(State), 0);
    chk("async_regwr", 32'(RegWrite), 0);
    chk("async_memrd", 32'(MemRead), 0);
    MemReady = 1'b1;
    @(posedge Clk); #1;
    chk("hold_state", 32'(State), 0);
    chk("hold_ctrl", 32'(vec), 32'(RST_VEC));
    Reset = 1'b0;
    MemReady = 1'b0;
    #1;
    chk("rel_memrd", 32'(MemRead), 1);
    chk("rel_regwr", 32'(RegWrite), 0);
    cyc(6'h00, 0, 0);
    cyc(6'h00, 1, 0);
    cyc(6'h00, 1, 1);
    cyc(6'h00, 1, 6);
    cyc(6'h00, 1, 7);
    cyc(6'h00, 1, 0);

    for (int i = 0; i < 10 && q.size() > 0; i++)
      @(posedge Clk);
    chk("drain", 32'(q.size()), 0);
    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

endmodule
